// File: rtl/sha256_top_if.sv
// Request/response bundle for the SHA-256 compression core: block words, chaining value, digest, done.
interface sha256_top_if;
  logic         start_in;
  logic [31:0]  w0_sha256, w1_sha256, w2_sha256, w3_sha256;
  logic [31:0]  w4_sha256, w5_sha256, w6_sha256, w7_sha256;
  logic [31:0]  w8_sha256, w9_sha256, w10_sha256, w11_sha256;
  logic [31:0]  w12_sha256, w13_sha256, w14_sha256, w15_sha256;
  logic [31:0]  A_i, B_i, C_i, D_i, E_i, F_i, G_i, H_i;
  logic [255:0] sha256_result;
  logic         sha256_done;

  modport master (
    output start_in,
    output w0_sha256, w1_sha256, w2_sha256, w3_sha256, w4_sha256, w5_sha256, w6_sha256, w7_sha256,
    output w8_sha256, w9_sha256, w10_sha256, w11_sha256, w12_sha256, w13_sha256, w14_sha256, w15_sha256,
    output A_i, B_i, C_i, D_i, E_i, F_i, G_i, H_i,
    input  sha256_result, sha256_done
  );

  modport slave (
    input  start_in,
    input  w0_sha256, w1_sha256, w2_sha256, w3_sha256, w4_sha256, w5_sha256, w6_sha256, w7_sha256,
    input  w8_sha256, w9_sha256, w10_sha256, w11_sha256, w12_sha256, w13_sha256, w14_sha256, w15_sha256,
    input  A_i, B_i, C_i, D_i, E_i, F_i, G_i, H_i,
    output sha256_result, sha256_done
  );
endinterface

// File: rtl/sha256_top.sv
// Single-block SHA-256 compression, one round per clock; done rises on the 66th posedge counting the start sample.
// Define SHA256_FIXED_IV_EN to load the FIPS IV instead of A_i..H_i.
module sha256_top (
  input logic         clk,
  input logic         reset,
  sha256_top_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  state_t       state_q, state_d;
  logic [5:0]   t_q, t_d;
  logic [31:0]  w_q [16], w_d [16];
  logic [31:0]  work_q [8], work_d [8];
  logic [31:0]  hreg_q [8], hreg_d [8];
  logic [255:0] result_q, result_d;
  logic         done_q, done_d;

  logic [31:0]  w_in [16];
  logic [31:0]  iv_in [8];
  logic [31:0]  t1, t2, w_new;

  always_comb begin
    w_in = '{bus.w0_sha256, bus.w1_sha256, bus.w2_sha256, bus.w3_sha256,
             bus.w4_sha256, bus.w5_sha256, bus.w6_sha256, bus.w7_sha256,
             bus.w8_sha256, bus.w9_sha256, bus.w10_sha256, bus.w11_sha256,
             bus.w12_sha256, bus.w13_sha256, bus.w14_sha256, bus.w15_sha256};
`ifdef SHA256_FIXED_IV_EN
    iv_in = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
              32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
`else
    iv_in = '{bus.A_i, bus.B_i, bus.C_i, bus.D_i, bus.E_i, bus.F_i, bus.G_i, bus.H_i};
`endif
  end

  always_comb begin
    state_d  = state_q;
    t_d      = t_q;
    w_d      = w_q;
    work_d   = work_q;
    hreg_d   = hreg_q;
    result_d = result_q;
    done_d   = done_q;

    t1 = work_q[7] + (rotr(work_q[4], 6) ^ rotr(work_q[4], 11) ^ rotr(work_q[4], 25))
       + ((work_q[4] & work_q[5]) ^ (~work_q[4] & work_q[6])) + K[t_q] + w_q[0];
    t2 = (rotr(work_q[0], 2) ^ rotr(work_q[0], 13) ^ rotr(work_q[0], 22))
       + ((work_q[0] & work_q[1]) ^ (work_q[0] & work_q[2]) ^ (work_q[1] & work_q[2]));
    // Appending W[t+16] every round keeps W[t] at the window head for all t.
    w_new = (rotr(w_q[14], 17) ^ rotr(w_q[14], 19) ^ (w_q[14] >> 10)) + w_q[9]
          + (rotr(w_q[1], 7) ^ rotr(w_q[1], 18) ^ (w_q[1] >> 3)) + w_q[0];

    case (state_q)
      IDLE: begin
        if (bus.start_in) begin
          w_d     = w_in;
          hreg_d  = iv_in;
          work_d  = iv_in;
          t_d     = 6'd0;
          state_d = ROUND;
        end
      end
      ROUND: begin
        work_d = '{t1 + t2, work_q[0], work_q[1], work_q[2],
                   work_q[3] + t1, work_q[4], work_q[5], work_q[6]};
        for (int i = 0; i < 15; i++) w_d[i] = w_q[i+1];
        w_d[15] = w_new;
        t_d     = t_q + 6'd1;
        if (t_q == 6'd63) state_d = FINAL;
      end
      FINAL: begin
        for (int i = 0; i < 8; i++) result_d[255-32*i -: 32] = hreg_q[i] + work_q[i];
        done_d  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        if (!bus.start_in) begin
          done_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      t_q      <= 6'd0;
      w_q      <= '{default: '0};
      work_q   <= '{default: '0};
      hreg_q   <= '{default: '0};
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      t_q      <= t_d;
      w_q      <= w_d;
      work_q   <= work_d;
      hreg_q   <= hreg_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign bus.sha256_result = result_q;
  assign bus.sha256_done   = done_q;
endmodule

// File: tb/tb_sha256_top.sv
// Scoreboarded bench for sha256_top: known digests, latency, handshake, mid-run reset, chaining.
module tb_sha256_top;
  localparam logic [255:0] IV_FIPS   = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] DIG_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] DIG_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  sha256_top_if bus ();
  sha256_top dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int errors = 0;
  logic [255:0] exp_q [$];
  logic [255:0] exp_dig;
  logic         done_prev = 1'b0;

  function automatic logic [31:0] rr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Plain FIPS 180-4 compression with a full 64-word schedule.
  function automatic logic [255:0] sha_model(input logic [255:0] iv, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] s1, s2;
    logic [255:0] r;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++)
      w[i] = (rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
           + (rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
    for (int i = 0; i < 8; i++) v[i] = iv[255-32*i -: 32];
    for (int i = 0; i < 64; i++) begin
      s1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[i] + w[i];
      s2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + s1;
      v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = s1 + s2;
    end
    for (int i = 0; i < 8; i++) r[255-32*i -: 32] = iv[255-32*i -: 32] + v[i];
    return r;
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic drive_block(input logic [511:0] blk, input logic [255:0] iv);
    bus.w0_sha256  = blk[511:480]; bus.w1_sha256  = blk[479:448];
    bus.w2_sha256  = blk[447:416]; bus.w3_sha256  = blk[415:384];
    bus.w4_sha256  = blk[383:352]; bus.w5_sha256  = blk[351:320];
    bus.w6_sha256  = blk[319:288]; bus.w7_sha256  = blk[287:256];
    bus.w8_sha256  = blk[255:224]; bus.w9_sha256  = blk[223:192];
    bus.w10_sha256 = blk[191:160]; bus.w11_sha256 = blk[159:128];
    bus.w12_sha256 = blk[127:96];  bus.w13_sha256 = blk[95:64];
    bus.w14_sha256 = blk[63:32];   bus.w15_sha256 = blk[31:0];
    bus.A_i = iv[255:224]; bus.B_i = iv[223:192]; bus.C_i = iv[191:160]; bus.D_i = iv[159:128];
    bus.E_i = iv[127:96];  bus.F_i = iv[95:64];   bus.G_i = iv[63:32];   bus.H_i = iv[31:0];
  endtask

  // Counts posedges from the start-sampling edge (1) up to the edge that raises done.
  task automatic wait_done(output int cyc);
    logic seen;
    seen = 1'b0;
    cyc = 0;
    while (!seen && cyc < 200) begin
      @(posedge clk);
      cyc++;
      #1;
      seen = bus.sha256_done;
    end
  endtask

  task automatic release_start();
    @(negedge clk);
    bus.start_in = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: each rising done pops one expected digest.
  always @(negedge clk) begin
    if (reset && bus.sha256_done && !done_prev) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: result %h with no digest expected", bus.sha256_result);
      end else begin
        exp_dig = exp_q.pop_front();
        if (bus.sha256_result !== exp_dig) begin
          errors++;
          $display("FAIL digest: got %h want %h", bus.sha256_result, exp_dig);
        end
      end
    end
    done_prev = bus.sha256_done;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int bad;
    logic [255:0] chain_exp;

    bus.start_in = 1'b0;
    drive_block(BLK_ABC, IV_FIPS);
    repeat (3) @(posedge clk);
    #1;
    check("reset_done", {255'b0, bus.sha256_done}, 256'd0);
    check("reset_result", bus.sha256_result, 256'd0);
    @(negedge clk);
    reset = 1'b1;

    // "abc", then hold start well past done.
    @(negedge clk);
    exp_q.push_back(DIG_ABC);
    drive_block(BLK_ABC, IV_FIPS);
    bus.start_in = 1'b1;
    wait_done(cyc);
    check("latency_abc", cyc, 66);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (!bus.sha256_done || bus.sha256_result !== DIG_ABC) bad++;
    end
    check("hold_stable", bad, 0);
    release_start();
    check("drop_done", {255'b0, bus.sha256_done}, 256'd0);
    check("drop_result", bus.sha256_result, DIG_ABC);

    // Empty message with inputs scrambled mid-run.
    @(negedge clk);
    exp_q.push_back(DIG_EMPTY);
    drive_block(BLK_EMPTY, IV_FIPS);
    bus.start_in = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    drive_block({16{32'hdeadbeef}}, {8{32'h12345678}});
    wait_done(cyc);
    check("latency_empty_scrambled", cyc, 56);

    // Start low for exactly one cycle, then "abc" again.
    release_start();
    @(negedge clk);
    exp_q.push_back(DIG_ABC);
    drive_block(BLK_ABC, IV_FIPS);
    bus.start_in = 1'b1;
    wait_done(cyc);
    check("latency_b2b", cyc, 66);
    release_start();

    // Abort at round 30.
    @(negedge clk);
    drive_block(BLK_ABC, IV_FIPS);
    bus.start_in = 1'b1;
    repeat (31) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    bus.start_in = 1'b0;
    @(posedge clk);
    #1;
    check("abort_done", {255'b0, bus.sha256_done}, 256'd0);
    check("abort_result", bus.sha256_result, 256'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    exp_q.push_back(DIG_ABC);
    bus.start_in = 1'b1;
    wait_done(cyc);
    check("latency_after_abort", cyc, 66);
    release_start();

    // Chaining from the "abc" digest.
`ifdef SHA256_FIXED_IV_EN
    chain_exp = DIG_EMPTY;
`else
    chain_exp = sha_model(DIG_ABC, BLK_EMPTY);
`endif
    @(negedge clk);
    exp_q.push_back(chain_exp);
    drive_block(BLK_EMPTY, DIG_ABC);
    bus.start_in = 1'b1;
    wait_done(cyc);
    check("latency_chain", cyc, 66);
    release_start();

    repeat (5) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
